// File: rtl/multiplexer_scan.sv
// -----------------------------------------------------------------------------
// multiplexer_scan
//
// Registered N-channel, W-bit multiplexer with two operating modes:
//   - direct : the channel addressed by `sel` is forwarded to the output.
//   - scan   : channels are walked round-robin, DWELL cycles per channel,
//              starting from `sel` at the moment the scan is entered.
// All outputs are registered on the same edge, so data, index, valid and
// wrap always describe the same channel.
//
// Optional feature macro: MULTIPLEXER_SCAN_MASK_EN
//   When defined, the `chanMask` port exists and the scan visits only the
//   channels whose mask bit is 1. When undefined, every channel is scanned.
//
// Ports:
//   clock    in   single clock, rising-edge active
//   reset    in   asynchronous, active-high
//   enable   in   0 = idle, outputs forced to zero
//   mode     in   0 = direct, 1 = scan
//   sel      in   [SEL_BITS]   direct channel / scan start channel
//   muxIn    in   [N*W]        channel k at bits [k*W +: W]
//   chanMask in   [N]          scan include mask (MULTIPLEXER_SCAN_MASK_EN only)
//   muxOut   out  [W]          registered channel data
//   chanOut  out  [SEL_BITS]   index of the channel shown on muxOut
//   valid    out               muxOut holds real channel data
//   wrap     out               one-cycle pulse when the scan returns to a
//                              lower-or-equal index
// -----------------------------------------------------------------------------
module multiplexer_scan #(
    parameter int NR_OF_INPUTS = 16,
    parameter int NR_OF_BITS   = 8,
    parameter int SEL_BITS     = 4,
    parameter int DWELL        = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               mode,
    input  logic [SEL_BITS-1:0]                sel,
    input  logic [NR_OF_INPUTS*NR_OF_BITS-1:0] muxIn,
`ifdef MULTIPLEXER_SCAN_MASK_EN
    input  logic [NR_OF_INPUTS-1:0]            chanMask,
`endif
    output logic [NR_OF_BITS-1:0]              muxOut,
    output logic [SEL_BITS-1:0]                chanOut,
    output logic                               valid,
    output logic                               wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Counter value at which the pointer moves on (DWELL=1 gives 0, i.e. every cycle).
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t                    state_r;
    state_t                    nextState_s;
    logic [SEL_BITS-1:0]       pointer_r;
    logic [SEL_BITS-1:0]       nextPointer_s;
    logic [7:0]                dwellCnt_r;
    logic [7:0]                nextCnt_s;
    logic [NR_OF_BITS-1:0]     nextMuxOut_s;
    logic [SEL_BITS-1:0]       nextChanOut_s;
    logic                      nextValid_s;
    logic                      nextWrap_s;

    logic [NR_OF_INPUTS-1:0]   scanMask_s;
    logic                      maskEmpty_s;
    logic                      selInRange_s;
    logic                      pointerEnabled_s;
    logic [SEL_BITS-1:0]       entryStart_s;
    logic [SEL_BITS-1:0]       advancePtr_s;

    // Data of channel idx; indices outside the channel range yield zero.
    function automatic logic [NR_OF_BITS-1:0] channelData(
        input logic [SEL_BITS-1:0]                idx,
        input logic [NR_OF_INPUTS*NR_OF_BITS-1:0] bus
    );
        logic [NR_OF_BITS-1:0] data;
        data = {NR_OF_BITS{1'b0}};
        for (int k = 0; k < NR_OF_INPUTS; k++) begin
            if (int'(idx) == k) begin
                data = bus[k*NR_OF_BITS +: NR_OF_BITS];
            end
        end
        return data;
    endfunction

    // Lowest enabled channel at or above start; if none, the lowest enabled
    // channel overall (wrap-around). Returns 0 for an empty mask.
    function automatic logic [SEL_BITS-1:0] firstEnabled(
        input int                      start,
        input logic [NR_OF_INPUTS-1:0] mask
    );
        logic [SEL_BITS-1:0] upper;
        logic [SEL_BITS-1:0] lowest;
        logic                upperFound;
        upper      = {SEL_BITS{1'b0}};
        lowest     = {SEL_BITS{1'b0}};
        upperFound = 1'b0;
        // Descending walk: the last hit is the lowest index.
        for (int k = NR_OF_INPUTS - 1; k >= 0; k--) begin
            if (mask[k]) begin
                lowest = SEL_BITS'(k);
                if (k >= start) begin
                    upper      = SEL_BITS'(k);
                    upperFound = 1'b1;
                end
            end
        end
        return upperFound ? upper : lowest;
    endfunction

    // Mask bit of channel idx without a variable bit-select on a narrower vector.
    function automatic logic maskBit(
        input logic [SEL_BITS-1:0]     idx,
        input logic [NR_OF_INPUTS-1:0] mask
    );
        logic bitVal;
        bitVal = 1'b0;
        for (int k = 0; k < NR_OF_INPUTS; k++) begin
            if (int'(idx) == k) begin
                bitVal = mask[k];
            end
        end
        return bitVal;
    endfunction

`ifdef MULTIPLEXER_SCAN_MASK_EN
    assign scanMask_s = chanMask;
`else
    assign scanMask_s = {NR_OF_INPUTS{1'b1}};
`endif

    assign maskEmpty_s      = ~|scanMask_s;
    assign selInRange_s     = (int'(sel) < NR_OF_INPUTS);
    assign pointerEnabled_s = maskBit(pointer_r, scanMask_s);
    // An out-of-range start channel falls back to channel 0.
    assign entryStart_s     = firstEnabled(selInRange_s ? int'(sel) : 0, scanMask_s);
    assign advancePtr_s     = firstEnabled(int'(pointer_r) + 1, scanMask_s);

    // Next state, next pointer/counter and next registered outputs.
    always_comb begin
        nextPointer_s = pointer_r;
        nextCnt_s     = 8'd0;
        nextMuxOut_s  = {NR_OF_BITS{1'b0}};
        nextChanOut_s = chanOut;
        nextValid_s   = 1'b0;
        nextWrap_s    = 1'b0;

        if (!enable) begin
            nextState_s = IDLE;
        end else if (!mode) begin
            nextState_s = DIRECT;
        end else begin
            nextState_s = SCAN;
        end

        case (nextState_s)
            IDLE: begin
                nextCnt_s = 8'd0;
            end
            DIRECT: begin
                nextChanOut_s = sel;
                if (selInRange_s) begin
                    nextMuxOut_s = channelData(sel, muxIn);
                    nextValid_s  = 1'b1;
                end else begin
                    nextMuxOut_s = {NR_OF_BITS{1'b0}};
                    nextValid_s  = 1'b0;
                end
            end
            SCAN: begin
                if (maskEmpty_s) begin
                    // Nothing to show: pointer and index freeze, data invalid.
                    nextValid_s = 1'b0;
                end else if (state_r != SCAN) begin
                    nextPointer_s = entryStart_s;
                    nextMuxOut_s  = channelData(entryStart_s, muxIn);
                    nextChanOut_s = entryStart_s;
                    nextValid_s   = 1'b1;
                end else if ((dwellCnt_r == DWELL_LAST) || !pointerEnabled_s) begin
                    // Dwell expired (or the current channel got masked off).
                    nextPointer_s = advancePtr_s;
                    nextMuxOut_s  = channelData(advancePtr_s, muxIn);
                    nextChanOut_s = advancePtr_s;
                    nextValid_s   = 1'b1;
                    nextWrap_s    = (advancePtr_s <= pointer_r);
                end else begin
                    nextCnt_s     = dwellCnt_r + 8'd1;
                    nextMuxOut_s  = channelData(pointer_r, muxIn);
                    nextChanOut_s = pointer_r;
                    nextValid_s   = 1'b1;
                end
            end
            default: begin
                nextCnt_s = 8'd0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Scan pointer, dwell counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pointer_r  <= {SEL_BITS{1'b0}};
            dwellCnt_r <= 8'd0;
            muxOut     <= {NR_OF_BITS{1'b0}};
            chanOut    <= {SEL_BITS{1'b0}};
            valid      <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            pointer_r  <= nextPointer_s;
            dwellCnt_r <= nextCnt_s;
            muxOut     <= nextMuxOut_s;
            chanOut    <= nextChanOut_s;
            valid      <= nextValid_s;
            wrap       <= nextWrap_s;
        end
    end

endmodule

// File: tb/tb_multiplexer_scan.sv
// -----------------------------------------------------------------------------
// tb_multiplexer_scan
//
// Scoreboard bench for multiplexer_scan. Two instances:
//   dutA : 16 channels x 8 bits, DWELL=4 (channel k data = {~k, k})
//   dutB : 3 channels x 8 bits, DWELL=1 (data 0x11, 0x22, 0x33)
// Stimulus tasks drive one cycle of inputs and push the hand-computed
// expected output for the following edge; a monitor pops and compares on
// every falling edge. Mask vectors run only when MULTIPLEXER_SCAN_MASK_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_multiplexer_scan;

    typedef struct packed {
        logic [7:0] mux;
        logic [3:0] chan;
        logic       valid;
        logic       wrap;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset;

    logic         enA, modeA;
    logic [3:0]   selA;
    logic [127:0] muxInA;
    logic [7:0]   muxOutA;
    logic [3:0]   chanOutA;
    logic         validA, wrapA;

    logic         enB, modeB;
    logic [3:0]   selB;
    logic [23:0]  muxInB;
    logic [7:0]   muxOutB;
    logic [3:0]   chanOutB;
    logic         validB, wrapB;

`ifdef MULTIPLEXER_SCAN_MASK_EN
    logic [15:0]  maskA;
    logic [2:0]   maskB;
`endif

    exp_t         qA[$];
    exp_t         qB[$];
    exp_t         eA, eB;
    int           vecA = 0;
    int           vecB = 0;
    int           checks = 0;
    int           failures = 0;
    logic [3:0]   kk;

    always #5 clock = ~clock;

    multiplexer_scan #(
        .NR_OF_INPUTS(16), .NR_OF_BITS(8), .SEL_BITS(4), .DWELL(4)
    ) dutA (
        .clock(clock), .reset(reset), .enable(enA), .mode(modeA),
        .sel(selA), .muxIn(muxInA),
`ifdef MULTIPLEXER_SCAN_MASK_EN
        .chanMask(maskA),
`endif
        .muxOut(muxOutA), .chanOut(chanOutA), .valid(validA), .wrap(wrapA)
    );

    multiplexer_scan #(
        .NR_OF_INPUTS(3), .NR_OF_BITS(8), .SEL_BITS(4), .DWELL(1)
    ) dutB (
        .clock(clock), .reset(reset), .enable(enB), .mode(modeB),
        .sel(selB), .muxIn(muxInB),
`ifdef MULTIPLEXER_SCAN_MASK_EN
        .chanMask(maskB),
`endif
        .muxOut(muxOutB), .chanOut(chanOutB), .valid(validB), .wrap(wrapB)
    );

    // One cycle of dutA stimulus plus the expected output after the next edge.
    task automatic stepA(input logic r, input logic en, input logic md, input logic [3:0] s,
                         input logic [7:0] m, input logic [3:0] c, input logic v, input logic w);
        exp_t t;
        @(negedge clock);
        #1;
        reset = r;
        enA   = en;
        modeA = md;
        selA  = s;
        t.mux = m; t.chan = c; t.valid = v; t.wrap = w;
        qA.push_back(t);
    endtask

`ifdef MULTIPLEXER_SCAN_MASK_EN
    task automatic stepAM(input logic [15:0] mk, input logic en, input logic md, input logic [3:0] s,
                          input logic [7:0] m, input logic [3:0] c, input logic v, input logic w);
        exp_t t;
        @(negedge clock);
        #1;
        maskA = mk;
        enA   = en;
        modeA = md;
        selA  = s;
        t.mux = m; t.chan = c; t.valid = v; t.wrap = w;
        qA.push_back(t);
    endtask
`endif

    task automatic stepB(input logic en, input logic md, input logic [3:0] s,
                         input logic [7:0] m, input logic [3:0] c, input logic v, input logic w);
        exp_t t;
        @(negedge clock);
        #1;
        enB   = en;
        modeB = md;
        selB  = s;
        t.mux = m; t.chan = c; t.valid = v; t.wrap = w;
        qB.push_back(t);
    endtask

    // Monitor: compare whatever each DUT presents against the scoreboard head.
    always @(negedge clock) begin
        if (qA.size() > 0) begin
            eA = qA.pop_front();
            vecA++;
            checks++;
            if ({muxOutA, chanOutA, validA, wrapA} !== eA) begin
                failures++;
                $display("FAIL dutA vec=%0d got mux=%h chan=%0d valid=%b wrap=%b want mux=%h chan=%0d valid=%b wrap=%b",
                         vecA, muxOutA, chanOutA, validA, wrapA, eA.mux, eA.chan, eA.valid, eA.wrap);
            end
        end
        if (qB.size() > 0) begin
            eB = qB.pop_front();
            vecB++;
            checks++;
            if ({muxOutB, chanOutB, validB, wrapB} !== eB) begin
                failures++;
                $display("FAIL dutB vec=%0d got mux=%h chan=%0d valid=%b wrap=%b want mux=%h chan=%0d valid=%b wrap=%b",
                         vecB, muxOutB, chanOutB, validB, wrapB, eB.mux, eB.chan, eB.valid, eB.wrap);
            end
        end
    end

    initial begin
        reset = 1'b1;
        enA = 1'b0; modeA = 1'b0; selA = 4'd0;
        enB = 1'b0; modeB = 1'b0; selB = 4'd0;
        for (int k = 0; k < 16; k++) begin
            kk = 4'(k);
            muxInA[k*8 +: 8] = {~kk, kk};
        end
        muxInB = {8'h33, 8'h22, 8'h11};
`ifdef MULTIPLEXER_SCAN_MASK_EN
        maskA = 16'hFFFF;
        maskB = 3'b111;
`endif

        // Reset held, then released while disabled.
        stepA(1'b1, 1'b0, 1'b0, 4'd0,  8'h00, 4'd0,  1'b0, 1'b0);
        stepA(1'b1, 1'b1, 1'b1, 4'd14, 8'h00, 4'd0,  1'b0, 1'b0);
        stepA(1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 4'd0,  1'b0, 1'b0);
        // Direct mode.
        stepA(1'b0, 1'b1, 1'b0, 4'd5,  8'hA5, 4'd5,  1'b1, 1'b0);
        stepA(1'b0, 1'b1, 1'b0, 4'd15, 8'h0F, 4'd15, 1'b1, 1'b0);
        // Scan from 14 (sel changes during the scan are ignored).
        stepA(1'b0, 1'b1, 1'b1, 4'd14, 8'h1E, 4'd14, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) stepA(1'b0, 1'b1, 1'b1, 4'd3, 8'h1E, 4'd14, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) stepA(1'b0, 1'b1, 1'b1, 4'd3, 8'h0F, 4'd15, 1'b1, 1'b0);
        stepA(1'b0, 1'b1, 1'b1, 4'd3, 8'hF0, 4'd0, 1'b1, 1'b1);
        stepA(1'b0, 1'b1, 1'b1, 4'd3, 8'hF0, 4'd0, 1'b1, 1'b0);
        // Disable, rescan from 6, drop enable mid-dwell, restart from 9.
        stepA(1'b0, 1'b0, 1'b1, 4'd3, 8'h00, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) stepA(1'b0, 1'b1, 1'b1, 4'd6, 8'h96, 4'd6, 1'b1, 1'b0);
        stepA(1'b0, 1'b0, 1'b1, 4'd6, 8'h00, 4'd6, 1'b0, 1'b0);
        stepA(1'b0, 1'b1, 1'b1, 4'd9, 8'h69, 4'd9, 1'b1, 1'b0);
        // Mode toggles take effect on the next edge.
        stepA(1'b0, 1'b1, 1'b0, 4'd2,  8'hD2, 4'd2,  1'b1, 1'b0);
        stepA(1'b0, 1'b1, 1'b1, 4'd2,  8'hD2, 4'd2,  1'b1, 1'b0);
        stepA(1'b0, 1'b1, 1'b0, 4'd7,  8'h87, 4'd7,  1'b1, 1'b0);
        stepA(1'b0, 1'b1, 1'b1, 4'd10, 8'h5A, 4'd10, 1'b1, 1'b0);

        // Asynchronous reset mid-scan clears outputs before any edge.
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({muxOutA, chanOutA, validA, wrapA} !== 14'd0) begin
            failures++;
            $display("FAIL async_reset got mux=%h chan=%0d valid=%b wrap=%b want all zero",
                     muxOutA, chanOutA, validA, wrapA);
        end
        stepA(1'b1, 1'b1, 1'b1, 4'd10, 8'h00, 4'd0,  1'b0, 1'b0);
        stepA(1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 4'd0,  1'b0, 1'b0);
        stepA(1'b0, 1'b1, 1'b1, 4'd12, 8'h3C, 4'd12, 1'b1, 1'b0);
        stepA(1'b0, 1'b0, 1'b1, 4'd12, 8'h00, 4'd12, 1'b0, 1'b0);

        // dutB: direct with out-of-range selects, then DWELL=1 scan.
        stepB(1'b1, 1'b0, 4'd1,  8'h22, 4'd1,  1'b1, 1'b0);
        stepB(1'b1, 1'b0, 4'd13, 8'h00, 4'd13, 1'b0, 1'b0);
        stepB(1'b1, 1'b0, 4'd3,  8'h00, 4'd3,  1'b0, 1'b0);
        stepB(1'b1, 1'b0, 4'd2,  8'h33, 4'd2,  1'b1, 1'b0);
        stepB(1'b1, 1'b1, 4'd0,  8'h11, 4'd0,  1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            stepB(1'b1, 1'b1, 4'd0, 8'h22, 4'd1, 1'b1, 1'b0);
            stepB(1'b1, 1'b1, 4'd0, 8'h33, 4'd2, 1'b1, 1'b0);
            stepB(1'b1, 1'b1, 4'd0, 8'h11, 4'd0, 1'b1, 1'b1);
        end
        stepB(1'b0, 1'b1, 4'd0,  8'h00, 4'd0, 1'b0, 1'b0);
        // Out-of-range start channel falls back to 0.
        stepB(1'b1, 1'b1, 4'd13, 8'h11, 4'd0, 1'b1, 1'b0);
        stepB(1'b1, 1'b1, 4'd13, 8'h22, 4'd1, 1'b1, 1'b0);
        stepB(1'b0, 1'b0, 4'd0,  8'h00, 4'd1, 1'b0, 1'b0);

`ifdef MULTIPLEXER_SCAN_MASK_EN
        // Masked scan 0,3,8,0 with wrap on the return to 0.
        stepAM(16'h0109, 1'b0, 1'b0, 4'd0, 8'h00, 4'd12, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) stepAM(16'h0109, 1'b1, 1'b1, 4'd0, 8'hF0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) stepAM(16'h0109, 1'b1, 1'b1, 4'd0, 8'hC3, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) stepAM(16'h0109, 1'b1, 1'b1, 4'd0, 8'h78, 4'd8, 1'b1, 1'b0);
        stepAM(16'h0109, 1'b1, 1'b1, 4'd0, 8'hF0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) stepAM(16'h0109, 1'b1, 1'b1, 4'd0, 8'hF0, 4'd0, 1'b1, 1'b0);
        stepAM(16'h0109, 1'b1, 1'b1, 4'd0, 8'hC3, 4'd3, 1'b1, 1'b0);
        // Empty mask freezes index, data invalid.
        for (int i = 0; i < 2; i++) stepAM(16'h0000, 1'b1, 1'b1, 4'd0, 8'h00, 4'd3, 1'b0, 1'b0);
        stepAM(16'h0109, 1'b0, 1'b1, 4'd4, 8'h00, 4'd3, 1'b0, 1'b0);
        // Entry on a masked channel moves up to the next enabled one.
        stepAM(16'h0109, 1'b1, 1'b1, 4'd4, 8'h78, 4'd8, 1'b1, 1'b0);
        stepAM(16'h0020, 1'b0, 1'b1, 4'd1, 8'h00, 4'd8, 1'b0, 1'b0);
        // Single enabled channel: wrap every DWELL cycles.
        for (int i = 0; i < 4; i++) stepAM(16'h0020, 1'b1, 1'b1, 4'd1, 8'hA5, 4'd5, 1'b1, 1'b0);
        stepAM(16'h0020, 1'b1, 1'b1, 4'd1, 8'hA5, 4'd5, 1'b1, 1'b1);
        stepAM(16'h0020, 1'b1, 1'b1, 4'd1, 8'hA5, 4'd5, 1'b1, 1'b0);
        // Direct mode ignores the mask.
        stepAM(16'h0020, 1'b1, 1'b0, 4'd1, 8'hE1, 4'd1, 1'b1, 1'b0);
`endif

        // Let the monitor drain the last expectations.
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if ((qA.size() != 0) || (qB.size() != 0)) begin
            failures++;
            $display("FAIL scoreboard_drain got pendingA=%0d pendingB=%0d want 0 and 0", qA.size(), qB.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiplexer_scan.md
# multiplexer_scan

Parametrised, registered N-channel, W-bit multiplexer: the successor to the fixed 16:1 single-bit plexer. It has two modes: a direct mode driven by `sel`, and an auto-scan mode that walks the channels round-robin with a programmable dwell time. It sits between banks of probe/data sources and a single shared consumer, such as a display driver or a bus monitor. Every output is registered, so channel data and channel index are always reported coherently.

## Interface
Parameters:
- `NR_OF_INPUTS`, default 16: channel count, legal range 2..16.
- `NR_OF_BITS`, default 8: width of each channel, legal range 1..32.
- `SEL_BITS`, default 4: width of the select and index signals; must be ≥ ceil(log2(NR_OF_INPUTS)).
- `DWELL`, default 4: number of cycles spent on each channel in scan mode, legal range 1..255.

Ports:
- `clock`: in, 1 bit. Single clock domain; all state changes on the rising edge.
- `reset`: in, 1 bit. Asynchronous, active-high.
- `enable`: in, 1 bit. When low, the block is idle and forces its outputs to zero.
- `mode`: in, 1 bit. 0 = direct, 1 = scan.
- `sel`: in, SEL_BITS. Channel for direct mode; also the starting channel when a scan begins.
- `muxIn`: in, NR_OF_INPUTS*NR_OF_BITS. Packed channel data; channel k occupies bits [k*NR_OF_BITS +: NR_OF_BITS].
- `chanMask`: in, NR_OF_INPUTS. Per-channel scan enable, 1 = include. Present only with `MULTIPLEXER_SCAN_MASK_EN`.
- `muxOut`: out, NR_OF_BITS. Registered data of the selected channel.
- `chanOut`: out, SEL_BITS. Index of the channel whose data is currently on `muxOut`.
- `valid`: out, 1 bit. `muxOut` holds real channel data.
- `wrap`: out, 1 bit. One-cycle pulse when the scan wraps back to a lower index.

## Operation
- Reset: `muxOut`=0, `chanOut`=0, `valid`=0, `wrap`=0, internal pointer=0, dwell counter=0, state IDLE.
- States and transitions:
  - IDLE is entered whenever `enable`=0.
  - DIRECT is entered when `enable`=1 and `mode`=0.
  - SCAN is entered when `enable`=1 and `mode`=1.
  - The state is re-evaluated every cycle; a mode change takes effect at the next edge.
- IDLE: `muxOut`←0, `valid`←0, `wrap`←0, `chanOut` holds, counter←0.
- DIRECT:
  - `chanOut`←`sel`, `muxOut`←channel `sel`, `valid`←1.
  - If `sel` ≥ NR_OF_INPUTS: `muxOut`←0 and `valid`←0.
  - `wrap`←0.
- SCAN entry (from IDLE or DIRECT):
  - Pointer←`sel` if `sel` < NR_OF_INPUTS, otherwise 0. Counter←0.
  - The first output appears at the entry edge.
- SCAN steady state:
  - Each cycle: `muxOut`←channel[pointer], `chanOut`←pointer, `valid`←1.
  - The counter increments each cycle. When it reaches DWELL-1 it clears and the pointer advances to the next channel.
  - Without the mask, the next channel is (pointer+1) mod NR_OF_INPUTS.
  - With DWELL=1, the pointer advances every cycle.
- `wrap` is asserted in the same cycle that `chanOut` first shows the new, lower-or-equal index after an advance, e.g. N-1→0.
- Out-of-range inputs never produce X; out-of-range selects yield zero data.

## Timing
- Latency is 1 cycle from `muxIn`/`sel`/`mode`/`enable` to the outputs. There is no combinational path from any input to any output.
- `muxOut`, `chanOut`, `valid` and `wrap` update on the same edge and are always mutually coherent.
- Reset mid-scan clears all outputs immediately (asynchronously). The first output after reset release follows the rules above on the next edge.
- `enable` deasserted mid-dwell: the scan position is discarded. Re-enabling in scan mode restarts from `sel`.
- `sel` changes during SCAN are ignored until the next SCAN entry.

## Configuration
- `MULTIPLEXER_SCAN_MASK_EN` defined:
  - The `chanMask` port exists.
  - A scan advance selects the lowest-index channel above the pointer whose mask bit is 1, wrapping to the lowest set bit; `wrap` pulses if the new index ≤ the old index.
  - Scan entry on a masked channel: the pointer moves to the next enabled channel from `sel`, wrapping.
  - With exactly one bit set, the scan stays on that channel and `wrap` pulses every DWELL cycles.
  - With all bits 0: `valid`=0, `muxOut`=0, and the pointer and `chanOut` hold.
  - DIRECT mode ignores the mask.
- Not defined: there is no `chanMask` port and all channels are always scanned.

## Test plan
- Reset: assert `reset` mid-operation, with N=16, W=8, DWELL=4 → all outputs 0 immediately; after release with `enable`=0, outputs stay 0.
- Direct mode: `mode`=0, `sel`=5, ch5=0xA5 → next edge `muxOut`=0xA5, `chanOut`=5, `valid`=1. With N=12 and `sel`=13 → `muxOut`=0, `valid`=0.
- Scan mode: `mode`=1, `sel`=14, DWELL=4 → `chanOut` shows 14 for 4 cycles, 15 for 4 cycles, then 0 with `wrap`=1 for exactly one cycle.
- Scan with DWELL=1, N=3 → `chanOut` sequence 0,1,2,0,… with `wrap` on every 0.
- Interruptions: drop `enable` for 1 cycle mid-dwell → `valid`=0 for that cycle, then the scan restarts at `sel`. Toggle `mode` 1→0 → DIRECT output on the next edge.
- Mask (macro on): `chanMask`=16'h0109, start at `sel`=0 → sequence 0,3,8,0 with `wrap` on each return to 0. Then `chanMask`=0 → `valid`=0, `chanOut` frozen.
